ex_unit_pipe: RTL and testbench

- Parametrised execute stage; successor to the single-cycle EX block.
- Sits between the ID/EX register and MEM.
- Uses valid/ready handshakes on both sides in place of a raw stall flag.
- Performs ADD/SUB in one cycle, runs MUL as a multi-cycle iterative operation, and resolves branches (taken flag plus target).

---
 rtl/ex_unit_pipe.sv | 254 +++++++++++++++++++++++++
 tb/tb_ex_unit_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_unit_pipe.sv
// ex_unit_pipe: parametrised execute stage with valid/ready handshakes.
// ADD/SUB and illegal ops complete in one cycle.
// MUL completes MUL_LAT cycles after accept.
// Branches produce a taken flag and a target address.
// Optional macro EX_OVF_DETECT_EN adds a registered signed-overflow output 'ovf'.
module ex_unit_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    input  logic [DATA_W-1:0] sign_ext,
    input  logic              alu_src,
    input  logic [1:0]        alu_op,
    input  logic              branch,
    input  logic [DATA_W-1:0] pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              illegal
`ifdef EX_OVF_DETECT_EN
    ,
    output logic              ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_ILL = 2'd3
    } op_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_mul_done;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                r_branch_taken;
    logic [DATA_W-1:0]   r_branch_target;
    logic                r_illegal;

    // operands and branch info of an in-flight MUL
    logic [DATA_W-1:0]   r_mul_a;
    logic [DATA_W-1:0]   r_mul_b;
    logic                r_mul_zero;
    logic                r_mul_taken;
    logic [DATA_W-1:0]   r_mul_target;

    op_t                 w_op;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic [DATA_W-1:0]   w_target;
    logic                w_zero;
    logic [DATA_W-1:0]   w_single_res;
    logic [DATA_W-1:0]   w_mul_res;
    logic                w_accept;
    logic                w_consume;

    assign w_b       = alu_src ? sign_ext : rt;
    assign w_sum     = rs + w_b;
    assign w_diff    = rs - w_b;
    assign w_zero    = (rs == w_b);
    assign w_target  = pc + {sign_ext[DATA_W-3:0], 2'b00};

    assign in_ready  = !reset && (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_out_valid && out_ready;

    assign out_valid     = r_out_valid;
    assign result        = r_result;
    assign zero          = r_zero;
    assign branch_taken  = r_branch_taken;
    assign branch_target = r_branch_target;
    assign illegal       = r_illegal;

    // Decode alu_op / funct into an internal operation
    always_comb begin
        w_op = OP_ILL;
        case (alu_op)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                case (sign_ext[5:0])
                    6'b000000: w_op = OP_ADD;
                    6'b000001: w_op = OP_SUB;
                    6'b000010: w_op = OP_MUL;
                    default:   w_op = OP_ILL;
                endcase
            end
            default: w_op = OP_ILL;
        endcase
    end

    // Result of single-cycle operations; illegal ops yield zero
    always_comb begin
        w_single_res = '0;
        case (w_op)
            OP_ADD:  w_single_res = w_sum;
            OP_SUB:  w_single_res = w_diff;
            default: w_single_res = '0;
        endcase
    end

`ifdef EX_OVF_DETECT_EN
    logic                  r_ovf;
    logic                  w_single_ovf;
    logic                  w_mul_ovf;
    logic [2*DATA_W-1:0]   w_mul_a_ext;
    logic [2*DATA_W-1:0]   w_mul_b_ext;
    logic [2*DATA_W-1:0]   w_prod;
    logic [DATA_W:0]       w_prod_hi;

    assign ovf         = r_ovf;
    assign w_mul_a_ext = {{DATA_W{r_mul_a[DATA_W-1]}}, r_mul_a};
    assign w_mul_b_ext = {{DATA_W{r_mul_b[DATA_W-1]}}, r_mul_b};
    assign w_prod      = w_mul_a_ext * w_mul_b_ext;
    assign w_mul_res   = w_prod[DATA_W-1:0];
    // product fits only if the top DATA_W+1 bits are all copies of the sign
    assign w_prod_hi   = w_prod[2*DATA_W-1:DATA_W-1];
    assign w_mul_ovf   = !((&w_prod_hi) || (~|w_prod_hi));

    // Signed overflow of the single-cycle operations
    always_comb begin
        w_single_ovf = 1'b0;
        case (w_op)
            OP_ADD:  w_single_ovf = (rs[DATA_W-1] == w_b[DATA_W-1]) &&
                                    (w_sum[DATA_W-1] != rs[DATA_W-1]);
            OP_SUB:  w_single_ovf = (rs[DATA_W-1] != w_b[DATA_W-1]) &&
                                    (w_diff[DATA_W-1] != rs[DATA_W-1]);
            default: w_single_ovf = 1'b0;
        endcase
    end

    // Overflow flag registered alongside result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_mul_done) begin
            r_ovf <= w_mul_ovf;
        end else if (w_accept && (w_op != OP_MUL)) begin
            r_ovf <= w_single_ovf;
        end
    end
`else
    assign w_mul_res = r_mul_a * r_mul_b;
`endif

    // FSM state and MUL counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: IDLE waits for a MUL accept, MUL counts down to completion
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mul_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (w_op == OP_MUL)) begin
                    w_state_nxt = S_MUL;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_MUL: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_mul_done  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Capture MUL operands and branch info at accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_zero   <= 1'b0;
            r_mul_taken  <= 1'b0;
            r_mul_target <= '0;
        end else if (w_accept && (w_op == OP_MUL)) begin
            r_mul_a      <= rs;
            r_mul_b      <= w_b;
            r_mul_zero   <= w_zero;
            r_mul_taken  <= branch && w_zero;
            r_mul_target <= w_target;
        end
    end

    // Output registers: load on MUL completion or single-cycle accept, clear on consume
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid     <= 1'b0;
            r_result        <= '0;
            r_zero          <= 1'b0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
            r_illegal       <= 1'b0;
        end else if (w_mul_done) begin
            r_out_valid     <= 1'b1;
            r_result        <= w_mul_res;
            r_zero          <= r_mul_zero;
            r_branch_taken  <= r_mul_taken;
            r_branch_target <= r_mul_target;
            r_illegal       <= 1'b0;
        end else if (w_accept && (w_op != OP_MUL)) begin
            r_out_valid     <= 1'b1;
            r_result        <= w_single_res;
            r_zero          <= w_zero;
            r_branch_taken  <= branch && w_zero;
            r_branch_target <= w_target;
            r_illegal       <= (w_op == OP_ILL);
        end else if (w_consume) begin
            r_out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_unit_pipe.sv
// Directed self-checking bench for ex_unit_pipe (DATA_W=32, MUL_LAT=4).
module tb_ex_unit_pipe;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MUL_LAT = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] sign_ext;
    logic              alu_src;
    logic [1:0]        alu_op;
    logic              branch;
    logic [DATA_W-1:0] pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;
    logic              illegal;
`ifdef EX_OVF_DETECT_EN
    logic              ovf;
`endif

    int n_tests;
    int n_fail;

    ex_unit_pipe #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rs            (rs),
        .rt            (rt),
        .sign_ext      (sign_ext),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .branch        (branch),
        .pc            (pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .illegal       (illegal)
`ifdef EX_OVF_DETECT_EN
        ,
        .ovf           (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // absolute time bound for the whole run
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [DATA_W-1:0] se, input logic src,
                          input logic [1:0] op, input logic br,
                          input logic [DATA_W-1:0] p);
        rs       = a;
        rt       = b;
        sign_ext = se;
        alu_src  = src;
        alu_op   = op;
        branch   = br;
        pc       = p;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_op('0, '0, '0, 1'b0, 2'b00, 1'b0, '0);
        repeat (2) tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h exp 0", result); end
        n_tests++; if ({zero, branch_taken, illegal} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b exp 000", {zero, branch_taken, illegal}); end
        n_tests++; if (branch_target !== 32'h0) begin n_fail++; $display("FAIL reset_target: got %h exp 0", branch_target); end
`ifdef EX_OVF_DETECT_EN
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b exp 0", ovf); end
`endif
        reset = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_add_imm;
        set_op(32'd5, 32'd99, 32'd7, 1'b1, 2'b00, 1'b0, 32'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b exp 1", out_valid); end
        n_tests++; if (result !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h exp %h", result, 32'd12); end
        n_tests++; if ({zero, illegal} !== 2'b00) begin n_fail++; $display("FAIL add_flags: got %b exp 00", {zero, illegal}); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_consume: got %b exp 0", out_valid); end
    endtask

    task automatic test_beq;
        set_op(32'h10, 32'h10, 32'd3, 1'b0, 2'b01, 1'b1, 32'h100);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL beq_result: got %h exp 0", result); end
        n_tests++; if ({out_valid, zero, branch_taken} !== 3'b111) begin n_fail++; $display("FAIL beq_flags: got %b exp 111", {out_valid, zero, branch_taken}); end
        n_tests++; if (branch_target !== 32'h10C) begin n_fail++; $display("FAIL beq_target: got %h exp 10c", branch_target); end
        tick();
    endtask

    task automatic test_mul;
        set_op(32'h10000, 32'h10000, 32'd2, 1'b0, 2'b10, 1'b0, 32'h0);
        in_valid = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_accept_ready: got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < MUL_LAT; k++) begin
            n_tests++; if ({in_ready, out_valid} !== 2'b00) begin n_fail++; $display("FAIL mul_busy_c%0d: ready/valid got %b exp 00", k, {in_ready, out_valid}); end
            tick();
        end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_latency: out_valid got %b exp 1", out_valid); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL mul_wrap_result: got %h exp 0", result); end
`ifdef EX_OVF_DETECT_EN
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL mul_wrap_ovf: got %b exp 1", ovf); end
`endif
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_consume: got %b exp 0", out_valid); end
        // small product, immediate operand is funct so B comes from rt
        set_op(32'd7, 32'd6, 32'd2, 1'b0, 2'b10, 1'b0, 32'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (MUL_LAT - 1) tick();
        n_tests++; if ({out_valid, result} !== {1'b1, 32'd42}) begin n_fail++; $display("FAIL mul_small: valid/result got %b/%h exp 1/2a", out_valid, result); end
`ifdef EX_OVF_DETECT_EN
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mul_small_ovf: got %b exp 0", ovf); end
`endif
        tick();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        set_op(32'd1, 32'd0, 32'd2, 1'b1, 2'b00, 1'b0, 32'h0);
        in_valid = 1'b1;
        tick();
        set_op(32'd10, 32'd20, 32'd0, 1'b0, 2'b00, 1'b0, 32'h0);
        #1;
        n_tests++; if ({out_valid, result} !== {1'b1, 32'd3}) begin n_fail++; $display("FAIL bp_first: valid/result got %b/%h exp 1/3", out_valid, result); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b exp 0", in_ready); end
        repeat (2) begin
            tick();
            n_tests++; if ({out_valid, result} !== {1'b1, 32'd3}) begin n_fail++; $display("FAIL bp_hold: valid/result got %b/%h exp 1/3", out_valid, result); end
        end
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_tests++; if ({out_valid, result} !== {1'b1, 32'd30}) begin n_fail++; $display("FAIL bp_second: valid/result got %b/%h exp 1/1e", out_valid, result); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        set_op(32'd9, 32'd4, 32'd7, 1'b0, 2'b10, 1'b0, 32'h0);
        in_valid = 1'b1;
        tick();
        n_tests++; if ({out_valid, illegal, result} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL ill_funct: valid/illegal/result got %b/%b/%h exp 1/1/0", out_valid, illegal, result); end
        set_op(32'd1, 32'd1, 32'd1, 1'b1, 2'b11, 1'b0, 32'h0);
        tick();
        n_tests++; if ({out_valid, illegal, result} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL ill_op11: valid/illegal/result got %b/%b/%h exp 1/1/0", out_valid, illegal, result); end
`ifdef EX_OVF_DETECT_EN
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ill_ovf: got %b exp 0", ovf); end
`endif
        set_op(32'd3, 32'd5, 32'd0, 1'b0, 2'b01, 1'b0, 32'h0);
        tick();
        n_tests++; if ({out_valid, illegal, result} !== {2'b10, 32'hFFFFFFFE}) begin n_fail++; $display("FAIL b2b_sub: valid/illegal/result got %b/%b/%h exp 1/0/fffffffe", out_valid, illegal, result); end
`ifdef EX_OVF_DETECT_EN
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_sub_ovf: got %b exp 0", ovf); end
`endif
        set_op(32'h7FFFFFFF, 32'd0, 32'd1, 1'b1, 2'b00, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        n_tests++; if ({out_valid, result} !== {1'b1, 32'h80000000}) begin n_fail++; $display("FAIL b2b_add: valid/result got %b/%h exp 1/80000000", out_valid, result); end
`ifdef EX_OVF_DETECT_EN
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL b2b_add_ovf: got %b exp 1", ovf); end
`endif
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul;
        out_ready = 1'b1;
        set_op(32'd3, 32'd3, 32'd2, 1'b0, 2'b10, 1'b0, 32'h0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_tests++; if ({out_valid, result} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL rstmul_clear: valid/result got %b/%h exp 0/0", out_valid, result); end
        tick();
        reset = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmul_ready: got %b exp 1", in_ready); end
        for (int k = 0; k < MUL_LAT + 2; k++) begin
            tick();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmul_stale_c%0d: out_valid got %b exp 0", k, out_valid); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_add_imm();
        test_beq();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
